// File: rtl/row_scanout.sv
// row_scanout -- raster timing generator and row-buffer scan-out for a
// ping-pong line buffer feeding a parallel RGB display.
//
// Ports:
//   clock         sole clock
//   reset         synchronous, active-high
//   address_read  read address into the front row buffer (pixel column)
//   data_read     buffer read data, valid one clock after address_read
//   swap          one-clock pulse exchanging front and back row buffers
//   row_request   one-clock pulse asking the writer to fill the back buffer
//   row_number    row the writer must fill, stable between requests
//   row_done      one-clock pulse from the writer: back buffer filled
//   hsync, vsync  active-low sync outputs
//   de            display enable
//   rgb           pixel output (zero outside the active area)
//   underrun      sticky flag: a row was not ready at its swap point
module row_scanout #(
   parameter int A        = 9,
   parameter int S        = 24,
   parameter int H_ACTIVE = 320,
   parameter int H_FP     = 8,
   parameter int H_SYNC   = 48,
   parameter int H_BP     = 24,
   parameter int V_ACTIVE = 240,
   parameter int V_FP     = 3,
   parameter int V_SYNC   = 4,
   parameter int V_BP     = 15
) (
   input  logic         clock,
   input  logic         reset,
   output logic [A-1:0] address_read,
   input  logic [S-1:0] data_read,
   output logic         swap,
   output logic         row_request,
   output logic [8:0]   row_number,
   input  logic         row_done,
   output logic         hsync,
   output logic         vsync,
   output logic         de,
   output logic [S-1:0] rgb,
   output logic         underrun
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int HS_BEGIN = H_ACTIVE + H_FP;
   localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
   localparam int VS_BEGIN = V_ACTIVE + V_FP;
   localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

   logic [HW-1:0] h;
   logic [VW-1:0] v;
   logic [HW-1:0] h_next;
   logic [VW-1:0] v_next;
   logic          h_wrap;
   logic [9:0]    nv_cur;
   logic [9:0]    nv_nxt;
   logic          visible_now;
   logic          line_end;
   logic          underrun_evt;
   logic          ready;
   logic          underrun_q;
   logic          de_s1;
   logic          hs_s1;
   logic          vs_s1;

   // Next visible row for a given line: {defined, row}. Defined on every
   // line whose successor is visible, plus the last line of the frame,
   // which prefetches row 0.
   function automatic logic [9:0] next_visible(input logic [VW-1:0] line);
      if (int'(line) == V_TOTAL - 1)
         return {1'b1, 9'd0};
      else if (int'(line) < V_ACTIVE - 1)
         return {1'b1, 9'(int'(line) + 1)};
      else
         return '0;
   endfunction

   always_comb begin
      h_wrap = (int'(h) == H_TOTAL - 1);
      h_next = h_wrap ? '0 : h + 1'b1;
      v_next = v;
      if (h_wrap)
         v_next = (int'(v) == V_TOTAL - 1) ? '0 : v + 1'b1;
   end

   always_comb begin
      nv_cur      = next_visible(v);
      nv_nxt      = next_visible(v_next);
      visible_now = (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE);
      line_end    = h_wrap && nv_cur[9];
   end

   // Request/swap/underrun are decoded from the counters so the request
   // appears in the very first cycle after reset release; reset gates them
   // so nothing fires while reset is held.
   always_comb begin
      address_read = visible_now ? A'(h) : '0;
      row_request  = !reset && (h == '0) && nv_cur[9];
      swap         = !reset && line_end && ready;
      underrun_evt = !reset && line_end && !ready;
      underrun     = !reset && (underrun_q || underrun_evt);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         h          <= '0;
         v          <= VW'(V_TOTAL - 1);
         row_number <= '0;
         ready      <= 1'b0;
         underrun_q <= 1'b0;
         de_s1      <= 1'b0;
         hs_s1      <= 1'b1;
         vs_s1      <= 1'b1;
         de         <= 1'b0;
         hsync      <= 1'b1;
         vsync      <= 1'b1;
         rgb        <= '0;
      end else begin
         h <= h_next;
         v <= v_next;
         // Loaded on the edge entering h=0 so it is valid alongside the
         // combinational row_request of that cycle.
         if (h_wrap && nv_nxt[9])
            row_number <= nv_nxt[8:0];
         // Clear on request wins over a coincident row_done.
         if (row_request)
            ready <= 1'b0;
         else if (row_done)
            ready <= 1'b1;
         if (underrun_evt)
            underrun_q <= 1'b1;
         // Stage 1 aligns timing with the buffer's one-clock read latency;
         // stage 2 is the output register.
         de_s1 <= visible_now;
         hs_s1 <= !((int'(h) >= HS_BEGIN) && (int'(h) < HS_END));
         vs_s1 <= !((int'(v) >= VS_BEGIN) && (int'(v) < VS_END));
         de    <= de_s1;
         hsync <= hs_s1;
         vsync <= vs_s1;
         rgb   <= de_s1 ? data_read : '0;
      end
   end

endmodule

// File: tb/tb_row_scanout.sv
// Self-checking bench for row_scanout. Horizontal timing is shortened to
// 48 clocks per line so full frames stay short; vertical timing is default.
module tb_row_scanout;

   localparam int A  = 9;
   localparam int S  = 24;
   localparam int HA = 32;
   localparam int HF = 4;
   localparam int HS = 8;
   localparam int HB = 4;
   localparam int HT = HA + HF + HS + HB;
   localparam int VA = 240;
   localparam int VT = 262;

   logic         clk = 1'b0;
   logic         reset;
   logic [A-1:0] address_read;
   logic [S-1:0] data_read;
   logic         swap;
   logic         row_request;
   logic [8:0]   row_number;
   logic         row_done;
   logic         hsync;
   logic         vsync;
   logic         de;
   logic [S-1:0] rgb;
   logic         underrun;

   always #5 clk = ~clk;

   row_scanout #(
      .A(A), .S(S),
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(240), .V_FP(3), .V_SYNC(4), .V_BP(15)
   ) dut (
      .clock(clk), .reset(reset), .address_read(address_read),
      .data_read(data_read), .swap(swap), .row_request(row_request),
      .row_number(row_number), .row_done(row_done), .hsync(hsync),
      .vsync(vsync), .de(de), .rgb(rgb), .underrun(underrun)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // expected counters: th/tv now, h1/v1 one cycle ago, h2/v2 two cycles ago
   int th = 0, tv = VT - 1, h1 = 0, v1 = 0, h2 = 0, v2 = 0, pv = 0;
   // row buffer and writer model
   int front = 238, back = 238, front_prev = 238, addr_prev = 0;
   int wr_delay = -1, late_row = -1, late_delay = -1;
   int wcnt = 0, w2cnt = 0, wrow = 0;
   logic dbl = 1'b0;
   int swap_cnt = 0;
   logic prev_swap = 1'b0, consec = 1'b0;

   // One clock: drive buffer data / writer response late in the cycle,
   // cross the edge, sample point is #1 after the edge.
   task automatic cycle();
      logic rst_edge;
      int d;
      #2;
      data_read  = {8'(front_prev), 8'(addr_prev), 8'hA5};
      front_prev = front;
      addr_prev  = int'(address_read);
      row_done   = 1'b0;
      if (reset) begin
         wcnt = 0;
         w2cnt = 0;
      end else begin
         if (wcnt > 0) begin
            wcnt--;
            if (wcnt == 0) begin
               row_done = 1'b1;
               back = wrow;
               if (dbl) w2cnt = 20;
            end
         end else if (w2cnt > 0) begin
            w2cnt--;
            if (w2cnt == 0) begin
               row_done = 1'b1;
               back = wrow;
            end
         end
         if (row_request) begin
            wrow = int'(row_number);
            d = (wrow == late_row) ? late_delay : wr_delay;
            if (d == 0) begin
               row_done = 1'b1;
               back = wrow;
            end else if (d > 0) begin
               wcnt = d;
            end
         end
         if (swap) begin
            swap_cnt++;
            if (prev_swap) consec = 1'b1;
            front = back;
         end
      end
      prev_swap = swap;
      rst_edge = reset;
      @(posedge clk);
      #1;
      h2 = h1; v2 = v1; h1 = th; v1 = tv;
      if (rst_edge) begin
         th = 0; tv = VT - 1; pv = 0;
      end else begin
         pv = (pv < 2) ? pv + 1 : 2;
         if (th == HT - 1) begin
            th = 0;
            tv = (tv == VT - 1) ? 0 : tv + 1;
         end else begin
            th++;
         end
      end
   endtask

   task automatic model_init();
      row_done = 1'b0; dbl = 1'b0; late_row = -1; late_delay = -1;
      wcnt = 0; w2cnt = 0; front = 238; back = 238; front_prev = 238;
      swap_cnt = 0; consec = 1'b0; prev_swap = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_init();
      cycle();
      cycle();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      wr_delay = -1;
      reset = 1'b1;
      model_init();
      cycle();
      cycle();
      n_checks++; if (row_request !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b exp 0", row_request); end
      n_checks++; if (swap !== 1'b0) begin n_fail++; $display("FAIL rst_swap got %b exp 0", swap); end
      n_checks++; if (row_number !== 9'd0) begin n_fail++; $display("FAIL rst_rownum got %0d exp 0", row_number); end
      n_checks++; if (de !== 1'b0 || rgb !== 24'h0) begin n_fail++; $display("FAIL rst_de_rgb got %b/%h exp 0/000000", de, rgb); end
      n_checks++; if (hsync !== 1'b1 || vsync !== 1'b1) begin n_fail++; $display("FAIL rst_sync got %b%b exp 11", hsync, vsync); end
      n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL rst_underrun got %b exp 0", underrun); end
      reset = 1'b0;
      #1;
      n_checks++; if (row_request !== 1'b1) begin n_fail++; $display("FAIL start_req got %b exp 1", row_request); end
      n_checks++; if (row_number !== 9'd0) begin n_fail++; $display("FAIL start_rownum got %0d exp 0", row_number); end
      for (int i = 1; i < HT; i++) begin
         cycle();
         if (th == HT - 2) begin
            n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL start_underrun_early got %b exp 0", underrun); end
         end
         if (th == HT - 1) begin
            n_checks++; if (swap !== 1'b0) begin n_fail++; $display("FAIL start_swap got %b exp 0", swap); end
            n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL start_underrun got %b exp 1", underrun); end
         end
      end
      cycle();
      n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL start_underrun_sticky got %b exp 1", underrun); end
      n_checks++; if (row_request !== 1'b1 || row_number !== 9'd1) begin n_fail++; $display("FAIL line0_req got %b/%0d exp 1/1", row_request, row_number); end
   endtask

   task automatic test_normal();
      logic exp_req, exp_swap, exp_de, nvdef;
      logic [S-1:0] exp_rgb;
      int exp_nv, de_cnt, req_cnt;
      do_reset();
      wr_delay = 20;
      de_cnt = 0;
      req_cnt = 0;
      for (int i = 0; i < VT * HT; i++) begin
         if (i > 0) cycle();
         nvdef    = (tv == VT - 1) || (tv < VA - 1);
         exp_nv   = (tv == VT - 1) ? 0 : tv + 1;
         exp_req  = (th == 0) && nvdef;
         exp_swap = (th == HT - 1) && nvdef;
         exp_de   = (pv == 2) && (v2 < VA) && (h2 < HA);
         exp_rgb  = exp_de ? {8'(v2), 8'(h2), 8'hA5} : '0;
         if (de === 1'b1) de_cnt++;
         if (row_request === 1'b1) req_cnt++;
         n_checks++; if (row_request !== exp_req) begin n_fail++; $display("FAIL norm_req v=%0d h=%0d got %b exp %b", tv, th, row_request, exp_req); end
         if (exp_req) begin
            n_checks++; if (row_number !== 9'(exp_nv)) begin n_fail++; $display("FAIL norm_rownum v=%0d got %0d exp %0d", tv, row_number, exp_nv); end
         end
         n_checks++; if (swap !== exp_swap) begin n_fail++; $display("FAIL norm_swap v=%0d h=%0d got %b exp %b", tv, th, swap, exp_swap); end
         n_checks++; if (de !== exp_de) begin n_fail++; $display("FAIL norm_de v=%0d h=%0d got %b exp %b", tv, th, de, exp_de); end
         n_checks++; if (rgb !== exp_rgb) begin n_fail++; $display("FAIL norm_rgb v=%0d h=%0d got %h exp %h", tv, th, rgb, exp_rgb); end
      end
      n_checks++; if (swap_cnt != 240) begin n_fail++; $display("FAIL norm_swap_count got %0d exp 240", swap_cnt); end
      n_checks++; if (req_cnt != 240) begin n_fail++; $display("FAIL norm_req_count got %0d exp 240", req_cnt); end
      n_checks++; if (de_cnt != 240 * HA) begin n_fail++; $display("FAIL norm_de_count got %0d exp %0d", de_cnt, 240 * HA); end
      n_checks++; if (consec !== 1'b0) begin n_fail++; $display("FAIL norm_swap_consecutive got %b exp 0", consec); end
      n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL norm_underrun got %b exp 0", underrun); end
   endtask

   // Continues straight on from test_normal for one more frame.
   task automatic test_sync();
      logic exp_hs, exp_vs, exp_de;
      int hs_cnt, vs_cnt;
      hs_cnt = 0;
      vs_cnt = 0;
      for (int i = 0; i < VT * HT; i++) begin
         cycle();
         exp_hs = !((h2 >= HA + HF) && (h2 < HA + HF + HS));
         exp_vs = !((v2 >= 243) && (v2 <= 246));
         exp_de = (v2 < VA) && (h2 < HA);
         if (hsync === 1'b0) hs_cnt++;
         if (vsync === 1'b0) vs_cnt++;
         n_checks++; if (hsync !== exp_hs) begin n_fail++; $display("FAIL sync_h v=%0d h=%0d got %b exp %b", v2, h2, hsync, exp_hs); end
         n_checks++; if (vsync !== exp_vs) begin n_fail++; $display("FAIL sync_v v=%0d h=%0d got %b exp %b", v2, h2, vsync, exp_vs); end
         n_checks++; if (de !== exp_de) begin n_fail++; $display("FAIL sync_de v=%0d h=%0d got %b exp %b", v2, h2, de, exp_de); end
      end
      n_checks++; if (hs_cnt != VT * HS) begin n_fail++; $display("FAIL sync_h_count got %0d exp %0d", hs_cnt, VT * HS); end
      n_checks++; if (vs_cnt != 4 * HT) begin n_fail++; $display("FAIL sync_v_count got %0d exp %0d", vs_cnt, 4 * HT); end
   endtask

   task automatic test_late_writer();
      logic done;
      done = 1'b0;
      do_reset();
      wr_delay = 20;
      late_row = 11;
      late_delay = HT - 1;
      for (int i = 0; i < 14 * HT && !done; i++) begin
         cycle();
         if (tv == 9 && th == HT - 1) begin
            n_checks++; if (swap !== 1'b1 || underrun !== 1'b0) begin n_fail++; $display("FAIL late_line9 swap/underrun got %b/%b exp 1/0", swap, underrun); end
         end
         if (tv == 10 && th == HT - 1) begin
            n_checks++; if (swap !== 1'b0 || underrun !== 1'b1) begin n_fail++; $display("FAIL late_line10 swap/underrun got %b/%b exp 0/1", swap, underrun); end
         end
         if (tv == 11 && th == 7) begin
            n_checks++; if (rgb !== 24'h0A05A5 || de !== 1'b1) begin n_fail++; $display("FAIL late_redisplay rgb/de got %h/%b exp 0a05a5/1", rgb, de); end
         end
         if (tv == 12 && th == 7) begin
            n_checks++; if (rgb !== 24'h0C05A5) begin n_fail++; $display("FAIL late_recover rgb got %h exp 0c05a5", rgb); end
         end
         if (tv == 12 && th == HT - 1) begin
            n_checks++; if (swap !== 1'b1 || underrun !== 1'b1) begin n_fail++; $display("FAIL late_line12 swap/underrun got %b/%b exp 1/1", swap, underrun); end
            done = 1'b1;
         end
      end
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL late_timeout got %b exp 1", done); end
   endtask

   task automatic test_coincident();
      logic done;
      done = 1'b0;
      do_reset();
      wr_delay = 20;
      late_row = 5;
      late_delay = 0;
      for (int i = 0; i < 7 * HT && !done; i++) begin
         cycle();
         if (tv == 3 && th == HT - 1) begin
            n_checks++; if (swap !== 1'b1) begin n_fail++; $display("FAIL coinc_line3_swap got %b exp 1", swap); end
         end
         if (tv == 4 && th == HT - 1) begin
            n_checks++; if (swap !== 1'b0 || underrun !== 1'b1) begin n_fail++; $display("FAIL coinc_line4 swap/underrun got %b/%b exp 0/1", swap, underrun); end
            done = 1'b1;
         end
      end
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL coinc_timeout got %b exp 1", done); end
      // two row_done pulses per line
      do_reset();
      wr_delay = 5;
      dbl = 1'b1;
      for (int i = 0; i < 4 * HT; i++) cycle();
      n_checks++; if (swap_cnt != 4) begin n_fail++; $display("FAIL double_done_swaps got %0d exp 4", swap_cnt); end
      n_checks++; if (consec !== 1'b0) begin n_fail++; $display("FAIL double_done_consecutive got %b exp 0", consec); end
      n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL double_done_underrun got %b exp 0", underrun); end
   endtask

   task automatic test_mid_reset();
      logic done;
      int de_bad;
      done = 1'b0;
      de_bad = 0;
      do_reset();
      wr_delay = 20;
      late_row = 50;
      late_delay = -1;
      for (int i = 0; i < 102 * HT && !done; i++) begin
         cycle();
         if (tv == 100 && th == HT - 1) done = 1'b1;
      end
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL midrst_timeout got %b exp 1", done); end
      n_checks++; if (swap !== 1'b1 || underrun !== 1'b1) begin n_fail++; $display("FAIL midrst_before swap/underrun got %b/%b exp 1/1", swap, underrun); end
      reset = 1'b1;
      #1;
      n_checks++; if (swap !== 1'b0 || row_request !== 1'b0) begin n_fail++; $display("FAIL midrst_during swap/req got %b/%b exp 0/0", swap, row_request); end
      wr_delay = -1;
      cycle();
      reset = 1'b0;
      #1;
      n_checks++; if (row_request !== 1'b1 || row_number !== 9'd0) begin n_fail++; $display("FAIL midrst_after req/rownum got %b/%0d exp 1/0", row_request, row_number); end
      n_checks++; if (de !== 1'b0 || underrun !== 1'b0) begin n_fail++; $display("FAIL midrst_after de/underrun got %b/%b exp 0/0", de, underrun); end
      for (int i = 1; i < HT; i++) begin
         cycle();
         if (de !== 1'b0) de_bad++;
         if (th == HT - 1) begin
            n_checks++; if (swap !== 1'b0) begin n_fail++; $display("FAIL midrst_swap got %b exp 0", swap); end
         end
      end
      cycle();
      n_checks++; if (de_bad != 0) begin n_fail++; $display("FAIL midrst_de_line261 got %0d exp 0", de_bad); end
      n_checks++; if (row_request !== 1'b1 || row_number !== 9'd1) begin n_fail++; $display("FAIL midrst_line0 req/rownum got %b/%0d exp 1/1", row_request, row_number); end
      n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL midrst_underrun got %b exp 1", underrun); end
   endtask

   initial begin
      reset = 1'b1;
      row_done = 1'b0;
      data_read = '0;
      test_reset();
      test_normal();
      test_sync();
      test_late_writer();
      test_coincident();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #3_000_000;
      n_fail++;
      $display("FAIL watchdog got timeout exp completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
